// File: rtl/param_arbiter_fsm.sv
// Two-state request arbiter: fixed-priority or round-robin selection with an
// optional hold limit that forces the owner off the bus when others are waiting.
module param_arbiter_fsm #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           mode,
  input  logic [N-1:0]   r,
  output logic [N-1:0]   g,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           expire
);

  localparam int CW = IDW + 1;
  localparam logic [7:0]     HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [7:0]     SAT_LIM  = (MAX_HOLD != 0) ? 8'(MAX_HOLD) : 8'hFF;
  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

  // Sparse encoding so any corrupted value falls into the default branch.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic           expire_q, expire_d;

  logic [N-1:0]   owner_oh;
  logic [N-1:0]   other_req;
  logic           owner_req;
  logic           forced;
  logic [IDW-1:0] fix_win;
  logic [IDW-1:0] rr_win;
  logic           rr_found;
  logic [CW-1:0]  rr_cand;
  logic [IDW-1:0] win;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign owner_oh[gi] = (owner_q == IDW'(gi));
    end
  endgenerate

  assign other_req = r & ~owner_oh;
  assign owner_req = |(r & owner_oh);
  assign forced    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM) &&
                     owner_req && (|other_req);

  always_comb begin
    fix_win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) fix_win = IDW'(i);
    end
  end

  // Scan last+1 .. last+N with a single conditional subtract instead of a modulo.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      rr_cand = {1'b0, last_q} + CW'(k);
      if (rr_cand >= CW'(N)) rr_cand = rr_cand - CW'(N);
      if (!rr_found && r[rr_cand[IDW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand[IDW-1:0];
      end
    end
  end

  assign win = mode ? rr_win : fix_win;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    expire_d   = 1'b0;
    case (state_q)
      IDLE: begin
        hold_cnt_d = 8'd0;
        if (|r) begin
          state_d    = GRANT;
          owner_d    = win;
          last_d     = win;
          hold_cnt_d = 8'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d    = IDLE;
          hold_cnt_d = 8'd0;
        end else if (forced) begin
          state_d    = IDLE;
          hold_cnt_d = 8'd0;
          expire_d   = 1'b1;
        end else if (hold_cnt_q != SAT_LIM) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      hold_cnt_q <= 8'd0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      expire_q   <= expire_d;
    end
  end

  assign busy     = (state_q == GRANT);
  assign g        = busy ? owner_oh : '0;
  assign grant_id = busy ? owner_q : '0;
  assign expire   = expire_q;

endmodule

// File: tb/tb_param_arbiter_fsm.sv
// Bench for param_arbiter_fsm (N=4, MAX_HOLD=4): a behavioural model pushes the
// expected outputs per driven cycle, directed scenarios add explicit value checks.
module tb_param_arbiter_fsm;

  localparam int N   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           mode = 1'b0;
  logic [N-1:0]   r = '0;
  logic [N-1:0]   g;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           expire;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           busy;
    logic           exp;
  } exp_t;

  exp_t sb_q[$];

  int   m_state = 0;
  int   m_owner = 0;
  int   m_last  = N - 1;
  int   m_hold  = 0;
  logic m_exp   = 1'b0;

  param_arbiter_fsm #(.N(N), .MAX_HOLD(MH), .IDW(IDW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mode     (mode),
    .r        (r),
    .g        (g),
    .grant_id (grant_id),
    .busy     (busy),
    .expire   (expire)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rv, input logic mv, input int lst);
    int idx;
    idx = lst;
    if (!mv) begin
      for (int i = 0; i < N; i++) if (rv[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (idx + 1) % N;
        if (rv[idx]) return idx;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input logic [N-1:0] rv, input logic mv, input logic rstv);
    logic [N-1:0] one;
    int w;
    one = 1;
    if (!rstv) begin
      m_state = 0; m_owner = 0; m_hold = 0; m_exp = 1'b0; m_last = N - 1;
    end else if (m_state == 0) begin
      m_exp = 1'b0;
      if (rv != 0) begin
        w = pick(rv, mv, m_last);
        m_owner = w; m_last = w; m_hold = 1; m_state = 1;
      end
    end else begin
      m_exp = 1'b0;
      if (!rv[m_owner]) begin
        m_state = 0; m_hold = 0;
      end else if (MH != 0 && m_hold == MH && (rv & ~(one << m_owner)) != 0) begin
        m_state = 0; m_hold = 0; m_exp = 1'b1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] rv, input logic mv, input logic rstv);
    exp_t e;
    logic [N-1:0] one;
    one = 1;
    r = rv; mode = mv; resetn = rstv;
    model_step(rv, mv, rstv);
    e.busy = (m_state == 1);
    e.g    = e.busy ? (one << m_owner) : '0;
    e.id   = e.busy ? IDW'(m_owner) : '0;
    e.exp  = m_exp;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = sb_q.pop_front();
    check_val("sb_g", 32'(g), 32'(e.g));
    check_val("sb_id", 32'(grant_id), 32'(e.id));
    check_val("sb_busy", 32'(busy), 32'(e.busy));
    check_val("sb_expire", 32'(expire), 32'(e.exp));
    $display("cyc %0d rst_n=%b mode=%b r=%b | g=%b id=%0d busy=%b expire=%b",
             cyc, rstv, mv, rv, g, grant_id, busy, expire);
  endtask

  initial begin
    // Reset
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    check_val("rst_g", 32'(g), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);

    // Fixed priority
    cycle(4'b1010, 1'b0, 1'b1);
    check_val("fp_first", 32'(g), 32'b0010);
    cycle(4'b1010, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    check_val("fp_gap", 32'(g), 32'h0);
    cycle(4'b1000, 1'b0, 1'b1);
    check_val("fp_next", 32'(g), 32'b1000);
    check_val("fp_id", 32'(grant_id), 32'd3);
    cycle(4'b0000, 1'b0, 1'b1);

    // Round-robin order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] oh;
      oh = 4'b0001 << (k % N);
      cycle(4'b1111, 1'b1, 1'b1);
      check_val("rr_grant", 32'(g), 32'(oh));
      cycle(4'b1111, 1'b1, 1'b1);
      check_val("rr_hold", 32'(g), 32'(oh));
      cycle(4'b1111 & ~oh, 1'b1, 1'b1);
      check_val("rr_gap", 32'(g), 32'h0);
    end

    // Hold limit
    cycle(4'b0001, 1'b0, 1'b1);
    check_val("hl_c1", 32'(g), 32'b0001);
    cycle(4'b0001, 1'b0, 1'b1);
    check_val("hl_c2", 32'(g), 32'b0001);
    cycle(4'b0101, 1'b0, 1'b1);
    check_val("hl_c3", 32'(g), 32'b0001);
    cycle(4'b0101, 1'b0, 1'b1);
    check_val("hl_c4", 32'(g), 32'b0001);
    cycle(4'b0101, 1'b0, 1'b1);
    check_val("hl_rel_g", 32'(g), 32'h0);
    check_val("hl_expire", 32'(expire), 32'h1);
    cycle(4'b0101, 1'b0, 1'b1);
    check_val("hl_regrant", 32'(g), 32'b0001);
    check_val("hl_exp_off", 32'(expire), 32'h0);
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);

    // Saturation with no competitor
    for (int k = 0; k < 10; k++) begin
      cycle(4'b0100, 1'b0, 1'b1);
      check_val("sat_g", 32'(g), 32'b0100);
      check_val("sat_exp", 32'(expire), 32'h0);
    end
    cycle(4'b0101, 1'b0, 1'b1);
    check_val("sat_rel_g", 32'(g), 32'h0);
    check_val("sat_expire", 32'(expire), 32'h1);
    cycle(4'b0000, 1'b0, 1'b1);
    check_val("sat_pulse", 32'(expire), 32'h0);

    // Reset mid-grant
    cycle(4'b0100, 1'b0, 1'b1);
    check_val("rmg_own", 32'(grant_id), 32'd2);
    cycle(4'b0100, 1'b0, 1'b0);
    check_val("rmg_g", 32'(g), 32'h0);
    check_val("rmg_busy", 32'(busy), 32'h0);
    cycle(4'b1111, 1'b1, 1'b1);
    check_val("rmg_first", 32'(g), 32'b0001);
    cycle(4'b0000, 1'b1, 1'b1);

    // Mode change during GRANT
    cycle(4'b0010, 1'b0, 1'b1);
    check_val("mc_own", 32'(g), 32'b0010);
    cycle(4'b0010, 1'b1, 1'b1);
    check_val("mc_keep1", 32'(g), 32'b0010);
    cycle(4'b0110, 1'b1, 1'b1);
    check_val("mc_keep2", 32'(g), 32'b0010);
    cycle(4'b0101, 1'b1, 1'b1);
    check_val("mc_rel", 32'(g), 32'h0);
    cycle(4'b0101, 1'b1, 1'b1);
    check_val("mc_rr", 32'(g), 32'b0100);
    cycle(4'b0000, 1'b1, 1'b1);

    // Random traffic against the model
    for (int k = 0; k < 200; k++) begin
      logic [N-1:0] rv;
      logic mv, rs;
      rv = 4'($urandom_range(0, 15));
      mv = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 29) != 0);
      cycle(rv, mv, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_arbiter_fsm.md
PARAM_ARBITER_FSM -- requirements
Module: param_arbiter_fsm

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum grant length in cycles while other requests are pending; 0 means unlimited; legal range 0..255.
REQ-003 Parameter IDW, default $clog2(N): width of grant_id.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-007 r  input  N  request vector; bit i is requester i.
REQ-008 g  output  N  grant vector; one-hot or all-zero.
REQ-009 grant_id  output  IDW  index of the current owner; 0 when no grant is active.
REQ-010 busy  output  1  high while any grant is active.
REQ-011 expire  output  1  one-cycle pulse marking a forced release by MAX_HOLD.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-013 The grant outputs SHALL be Moore outputs, derived from registered state only.
REQ-014 In GRANT, g SHALL equal the one-hot of owner, grant_id SHALL equal owner, and busy SHALL be 1.
REQ-015 In IDLE, g SHALL be 0, grant_id SHALL be 0 and busy SHALL be 0.
REQ-016 In IDLE with r == 0, the FSM SHALL stay in IDLE.
REQ-017 In IDLE with r != 0, the FSM SHALL move to GRANT on the next edge, owner = winner.
- Grant latency is therefore one cycle from request to g.
REQ-018 With mode = 0, the winner SHALL be the lowest set index of r.
REQ-019 With mode = 1, the winner SHALL be the first set index of r searching last+1, last+2, ..., wrapping modulo N, ending at last.
REQ-020 mode SHALL be sampled only in IDLE.
- A change of mode during GRANT has no effect until the next arbitration.
REQ-021 last SHALL be updated to the winner on every IDLE-to-GRANT transition, in both modes.
REQ-022 hold_cnt SHALL be 1 in the first GRANT cycle and increment each further GRANT cycle, saturating at MAX_HOLD.
REQ-023 In GRANT, if r[owner] == 0, the FSM SHALL return to IDLE on the next edge.
- This is a normal release; expire stays 0.
REQ-024 In GRANT, forced release SHALL occur when all of the following hold: MAX_HOLD != 0, hold_cnt == MAX_HOLD, r[owner] == 1, and (r & ~onehot(owner)) != 0.
- The FSM returns to IDLE on the next edge.
- expire is 1 during that first IDLE cycle only.
REQ-025 If the hold limit is reached but no other requester is pending, the grant SHALL continue with hold_cnt saturated.
- Forced release occurs in the first later cycle in which another request appears.
REQ-026 Every release SHALL pass through at least one IDLE cycle before any new grant.
- There are no back-to-back grants without that IDLE gap.
REQ-027 Requests from non-owners during GRANT SHALL NOT affect g.
- Exception: the forced-release condition of REQ-024.
REQ-028 Out-of-range or illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-029 While resetn == 0 at a rising clk, the block SHALL enter IDLE with hold_cnt = 0, expire = 0 and last = N-1.
- Consequence: the first round-robin search starts at index 0.
REQ-030 Reset SHALL take priority over all transitions, including mid-grant and forced release.
- g, busy and grant_id are 0 in the cycle after the reset edge.
REQ-031 Outputs before the first reset edge are undefined.
- Verification SHALL check outputs only after reset.

Verification
REQ-032 The bench SHALL use N=4, MAX_HOLD=4 and cover these directed scenarios:
- Fixed priority: mode=0, r=4'b1010 held -> g=4'b0010 one cycle later. Then drop r[1] -> one cycle g=0, then g=4'b1000.
- Round-robin: mode=1, r=4'b1111 held, each owner drops its bit for one cycle after 2 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Hold limit: mode=0, r[0] held, r[2] raised at cycle 2 -> g=4'b0001 for exactly 4 cycles. Then expire=1 with g=0 for one cycle, then g=4'b0001 again (fixed priority).
- Saturation: r=4'b0100 only, held 10 cycles -> g=4'b0100 continuously, expire never 1. Raise r[0] at cycle 10 -> release next edge, expire=1.
- Reset mid-grant: owner 2 in GRANT, resetn=0 for one edge -> next cycle g=0, busy=0. With mode=1 and r=4'b1111, first grant after reset is index 0.
- Mode change in GRANT: set mode 0->1 while owner is 1 -> owner unchanged until release; next arbitration uses round-robin from last=1.
